debug_board_reader: RTL



---
 rtl/debug_reader_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 23 ++
 rtl/debug_board_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/debug_reader_pkg.sv
`default_nettype none
//==== debug_reader_pkg : shared types and constants for the debug board reader (rev 1.0) ====
package debug_reader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2,
    NEXT = 2'd3
  } state_t;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] P1      = 2'b01;
  localparam logic [1:0] P2      = 2'b10;
  localparam logic [1:0] INVALID = 2'b11;

  localparam int DEF_ROWS = 6;
  localparam int DEF_COLS = 7;
  localparam int CNT_W    = 6;

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
//==== sync_2ff : 1-bit two-flop synchronizer, async active-low reset to 0 (rev 1.0) ====
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule
`default_nettype wire

// File: rtl/debug_board_reader.sv
`default_nettype none
//==== debug_board_reader : host-side req/ack reader of the connect-four board (rev 1.0) ====
//==== Optional: define DEBUG_READER_ACK_SYNC_EN to pass dbg_ack through a 2-flop synchronizer ====
module debug_board_reader
  import debug_reader_pkg::*;
#(
  parameter int ROWS           = DEF_ROWS,
  parameter int COLS           = DEF_COLS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     dbg_req,
  output logic [2:0]               dbg_row,
  output logic [2:0]               dbg_col,
  input  logic                     dbg_ack,
  input  logic [1:0]               dbg_data,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [2*ROWS*COLS-1:0]   board_out,
  output logic [CNT_W-1:0]         changed_cnt
);

  localparam int CELLS = ROWS * COLS;
  localparam int BIT_W = $clog2(2 * CELLS);

  state_t           state;
  state_t           state_nx;
  logic             ack_s;
  logic [7:0]       tmo_cnt;
  logic             last_col;
  logic             last_row;
  logic             tmo_hit;
  logic             accept;
  logic             capture;
  logic             abort;
  logic [BIT_W-1:0] base;
  logic [1:0]       old_code;

`ifdef DEBUG_READER_ACK_SYNC_EN
  sync_2ff u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dbg_ack),
    .q     (ack_s)
  );
`else
  assign ack_s = dbg_ack;
`endif

  assign last_col = (dbg_col == 3'(COLS - 1));
  assign last_row = (dbg_row == 3'(ROWS - 1));
  assign tmo_hit  = (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign base     = BIT_W'(dbg_row) * BIT_W'(2 * COLS) + BIT_W'({dbg_col, 1'b0});
  assign old_code = board_out[base +: 2];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    dbg_req  = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = REQ;
        end
      end
      REQ: begin
        dbg_req = 1'b1;
        if (ack_s) begin
          capture  = 1'b1;
          state_nx = REL;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      REL: begin
        if (!ack_s) begin
          state_nx = NEXT;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      NEXT: begin
        if (last_col && last_row) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else begin
          state_nx = REQ;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Phase timer restarts whenever the FSM changes state, so each phase gets the full budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt     <= 8'd0;
      dbg_row     <= 3'd0;
      dbg_col     <= 3'd0;
      timeout_err <= 1'b0;
      changed_cnt <= '0;
      board_out   <= {CELLS{EMPTY}};
    end else begin
      if (state_nx != state)
        tmo_cnt <= 8'd0;
      else if (state == REQ || state == REL)
        tmo_cnt <= tmo_cnt + 8'd1;

      if (accept) begin
        dbg_row     <= 3'd0;
        dbg_col     <= 3'd0;
        changed_cnt <= '0;
        timeout_err <= 1'b0;
      end

      if (capture) begin
        board_out[base +: 2] <= dbg_data;
        if (dbg_data != old_code && changed_cnt != {CNT_W{1'b1}})
          changed_cnt <= changed_cnt + 1'b1;
      end

      if (abort)
        timeout_err <= 1'b1;

      if (state == NEXT && !(last_col && last_row)) begin
        if (last_col) begin
          dbg_col <= 3'd0;
          dbg_row <= dbg_row + 3'd1;
        end else begin
          dbg_col <= dbg_col + 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire
